pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Generates per-stage enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three conditions: load-use hazards, taken branches/jumps, and data-memory wait states.
- Includes a watchdog that freezes the pipe if data memory never responds.

Parameters:
REG_ADDR_WIDTH, `REG_ADDR_WIDTH, register index width
MEM_TIMEOUT, 64, max consecutive data-memory wait cycles before error; 0 = watchdog disabled
CNT_WIDTH, 32, width of optional performance counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
id_rs1  in  REG_ADDR_WIDTH  IF/ID.RegisterRs1
id_rs2  in  REG_ADDR_WIDTH  IF/ID.RegisterRs2
ex_inst_opcode  in  7  ID/EX instruction opcode
ex_rd  in  REG_ADDR_WIDTH  ID/EX.RegisterRd
ex_branch_taken  in  1  branch/JAL/JALR in EX resolved taken
mem_inst_opcode  in  7  EX/MEM instruction opcode
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID load bubble
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX load bubble
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
mem_wb_flush  out  1  MEM/WB load bubble
ctrl_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
mem_timeout_err  out  1  sticky watchdog error
stall_cnt  out  CNT_WIDTH  stall cycles (optional)
flush_cnt  out  CNT_WIDTH  flush events (optional)

Behaviour:
Definitions:
- LOAD = 7'b0000011; STORE = 7'b0100011.
- mem_busy = (mem_inst_opcode is LOAD or STORE) && !dmem_ready.
- load_use = ex_inst_opcode==LOAD && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).

Reset (reset_n low, asynchronous):
- State RUN; wait_cnt = 0; mem_timeout_err = 0; counters = 0.
- All *_en = 0 and all *_flush = 0 while reset_n is low.

Timing:
- Controls are combinational from the registered state and the current inputs, so they take effect at the same clock edge.
- State, wait_cnt, err flag and counters are registered.

Priority per cycle (RUN or MEM_WAIT), highest first:
1. mem_busy:
   - pc_en = if_id_en = id_ex_en = ex_mem_en = 0.
   - mem_wb_en = 1, mem_wb_flush = 1 (bubble into WB).
   - Next state MEM_WAIT; wait_cnt += 1 (saturating).
   - A pending ex_branch_taken or load_use is ignored this cycle; it remains held in the frozen ID/EX and is re-evaluated when released.
2. ex_branch_taken:
   - All enables = 1; if_id_flush = 1, id_ex_flush = 1 (squash 2 younger instructions).
   - load_use is ignored because the younger instruction is squashed.
3. load_use:
   - pc_en = 0, if_id_en = 0.
   - id_ex_en = 1, id_ex_flush = 1 (one-cycle bubble).
   - ex_mem_en = 1, mem_wb_en = 1.
   - Exactly 1 stall cycle per load-use pair.
4. Otherwise: all enables = 1, all flushes = 0.

FSM transitions:
- MEM_WAIT -> RUN in the cycle mem_busy drops; that cycle follows the priority list; wait_cnt cleared.
- wait_cnt reaching MEM_TIMEOUT (MEM_TIMEOUT != 0) while mem_busy:
  - Next state ERR; mem_timeout_err = 1.
- ERR:
  - All enables 0, all flushes 0; inputs ignored.
  - Exit only via reset.
- Back-to-back memory ops each get an independent wait_cnt; the count restarts from 0 after any ready cycle.
- Flushes are only valid with the matching enable: a flush with enable 0 is never driven.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cnt increments every cycle pc_en==0 outside ERR (mem_busy or load_use).
  - flush_cnt increments once per cycle ex_branch_taken takes effect.
  - Both counters wrap at 2^CNT_WIDTH and reset to 0.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: ex LOAD rd=5, id_rs2=5, dmem_ready=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1.
- Same setup with ex_rd=0 -> no stall.
- Taken branch: ex_branch_taken=1 together with a load_use match -> if_id_flush=id_ex_flush=1, pc_en=1; flush_cnt +1 (feature on).
- Memory wait: mem LOAD, dmem_ready low 3 cycles -> ctrl_state=1, upstream enables 0 and mem_wb_flush=1 for 3 cycles; ready -> RUN, stall_cnt=3.
- Watchdog: MEM_TIMEOUT=4, dmem_ready held low -> ERR after 4 wait cycles, mem_timeout_err=1, all enables 0; ready=1 afterwards has no effect.
- Reset mid-MEM_WAIT: reset_n low -> all outputs 0 immediately; after release, state RUN, counters 0, normal flow resumes.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enable/flush from load-use, taken-branch and dmem-wait conditions, plus a dmem watchdog.
// Controls are combinational from the registered state and current inputs. Optional counters are under PIPE_PERF_CNT_EN.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module pipe_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [6:0]                ex_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_branch_taken,
    input  logic [6:0]                mem_inst_opcode,
    input  logic                      dmem_ready,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      if_id_flush,
    output logic                      id_ex_en,
    output logic                      id_ex_flush,
    output logic                      ex_mem_en,
    output logic                      mem_wb_en,
    output logic                      mem_wb_flush,
    output logic [1:0]                ctrl_state,
    output logic                      mem_timeout_err,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Wide enough to hold MEM_TIMEOUT itself; still 1 bit when the watchdog is off.
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt, wait_inc;
    logic              err_q, err_nxt;
    logic              mem_busy, load_use, wait_limit;

    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c;
    logic ex_mem_en_c, mem_wb_en_c, mem_wb_flush_c;

    assign mem_busy = ((mem_inst_opcode == OP_LOAD) || (mem_inst_opcode == OP_STORE)) && !dmem_ready;

    assign load_use = (ex_inst_opcode == OP_LOAD) && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign wait_inc   = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
    assign wait_limit = (MEM_TIMEOUT != 0) && (wait_inc >= TIMEOUT_V);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        err_nxt        = err_q;
        pc_en_c        = 1'b0;
        if_id_en_c     = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_en_c     = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_en_c    = 1'b0;
        mem_wb_en_c    = 1'b0;
        mem_wb_flush_c = 1'b0;

        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    // Freeze everything up to EX/MEM; branch/load-use stay held in ID/EX.
                    mem_wb_en_c    = 1'b1;
                    mem_wb_flush_c = 1'b1;
                    wait_cnt_nxt   = wait_inc;
                    if (wait_limit) begin
                        state_nxt = ST_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_MEM_WAIT;
                    end
                end else begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                    if (ex_branch_taken) begin
                        pc_en_c       = 1'b1;
                        if_id_en_c    = 1'b1;
                        if_id_flush_c = 1'b1;
                        id_ex_en_c    = 1'b1;
                        id_ex_flush_c = 1'b1;
                        ex_mem_en_c   = 1'b1;
                        mem_wb_en_c   = 1'b1;
                    end else if (load_use) begin
                        id_ex_en_c    = 1'b1;
                        id_ex_flush_c = 1'b1;
                        ex_mem_en_c   = 1'b1;
                        mem_wb_en_c   = 1'b1;
                    end else begin
                        pc_en_c     = 1'b1;
                        if_id_en_c  = 1'b1;
                        id_ex_en_c  = 1'b1;
                        ex_mem_en_c = 1'b1;
                        mem_wb_en_c = 1'b1;
                    end
                end
            end
            default: begin
                // ERR (and any illegal encoding) holds the pipe frozen until reset.
                state_nxt    = state;
                wait_cnt_nxt = wait_cnt;
            end
        endcase
    end

    assign pc_en        = reset_n & pc_en_c;
    assign if_id_en     = reset_n & if_id_en_c;
    assign if_id_flush  = reset_n & if_id_flush_c;
    assign id_ex_en     = reset_n & id_ex_en_c;
    assign id_ex_flush  = reset_n & id_ex_flush_c;
    assign ex_mem_en    = reset_n & ex_mem_en_c;
    assign mem_wb_en    = reset_n & mem_wb_en_c;
    assign mem_wb_flush = reset_n & mem_wb_flush_c;

    assign ctrl_state      = state;
    assign mem_timeout_err = err_q;

`ifdef PIPE_PERF_CNT_EN
    logic                 stall_evt, flush_evt;
    logic [CNT_WIDTH-1:0] stall_q, flush_q;

    assign stall_evt = (state != ST_ERR) && !pc_en_c;
    assign flush_evt = (state != ST_ERR) && !mem_busy && ex_branch_taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt) stall_q <= stall_q + CNT_WIDTH'(1);
            if (flush_evt) flush_q <= flush_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed scoreboard bench for pipe_hazard_ctrl (watchdog limit 4).
module tb_pipe_hazard_ctrl;

    localparam int RA   = 5;
    localparam int TMO  = 4;
    localparam int CW   = 32;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [RA-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic [6:0]    ex_inst_opcode = ALU, mem_inst_opcode = ALU;
    logic          ex_branch_taken = 1'b0, dmem_ready = 1'b1;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_en, mem_wb_flush, mem_timeout_err;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.REG_ADDR_WIDTH(RA), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_inst_opcode(ex_inst_opcode), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_inst_opcode(mem_inst_opcode), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush), .ctrl_state(ctrl_state),
        .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    ctl;
        logic [1:0]    st;
        logic          err;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // Reference model state: mode 0 run, 1 waiting on memory, 2 dead.
    int            m_mode = 0;
    int            m_waits = 0;
    logic          m_err = 1'b0;
    logic [CW-1:0] m_stalls = '0, m_flushes = '0;

    task automatic step(input logic rn, input logic [RA-1:0] r1, input logic [RA-1:0] r2,
                        input logic [6:0] eop, input logic [RA-1:0] erd, input logic br,
                        input logic [6:0] mop, input logic rdy);
        exp_t e;
        bit   busy, lu;
        @(negedge clk);
        reset_n = rn; id_rs1 = r1; id_rs2 = r2; ex_inst_opcode = eop; ex_rd = erd;
        ex_branch_taken = br; mem_inst_opcode = mop; dmem_ready = rdy;
        if (!rn) begin
            m_mode = 0; m_waits = 0; m_err = 1'b0; m_stalls = '0; m_flushes = '0;
            e = '0;
            exp_q.push_back(e);
            return;
        end
        busy = ((mop == LD) || (mop == ST)) && !rdy;
        lu   = (eop == LD) && (erd != 0) && ((erd == r1) || (erd == r2));
        e.st  = 2'(m_mode);
        e.err = m_err;
        e.sc  = m_stalls;
        e.fc  = m_flushes;
        // ctl order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush
        if (m_mode == 2)  e.ctl = 8'b0000_0000;
        else if (busy)    e.ctl = 8'b0000_0011;
        else if (br)      e.ctl = 8'b1111_1110;
        else if (lu)      e.ctl = 8'b0001_1110;
        else              e.ctl = 8'b1101_0110;
        exp_q.push_back(e);
        if (m_mode != 2) begin
`ifdef PIPE_PERF_CNT_EN
            if (!e.ctl[7]) m_stalls = m_stalls + 1;
            if (!busy && br) m_flushes = m_flushes + 1;
`endif
            if (busy) begin
                m_waits++;
                if (TMO != 0 && m_waits >= TMO) begin m_mode = 2; m_err = 1'b1; end
                else m_mode = 1;
            end else begin
                m_waits = 0;
                m_mode  = 0;
            end
        end
    endtask

    task automatic rand_step(input logic rn);
        logic [6:0] eop, mop;
        int k;
        k = $urandom_range(0, 9);
        eop = (k < 5) ? LD : (k < 7) ? ALU : (k < 9) ? IMM : ST;
        k = $urandom_range(0, 9);
        mop = (k < 3) ? LD : (k < 5) ? ST : ALU;
        step(rn, RA'($urandom_range(0, 7)), RA'($urandom_range(0, 7)), eop,
             RA'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), mop,
             ($urandom_range(0, 9) < 7));
    endtask

    // Stimulus
    initial begin
        repeat (3) step(0, 0, 0, ALU, 0, 0, ALU, 1);
        step(1, 0, 0, ALU, 0, 0, ALU, 1);
        // load-use on rs2, then the bubble has advanced
        step(1, 1, 5, LD, 5, 0, ALU, 1);
        step(1, 1, 5, ALU, 0, 0, LD, 1);
        // rd = x0 never stalls
        step(1, 0, 0, LD, 0, 0, ALU, 1);
        step(1, 3, 0, LD, 3, 0, ALU, 1);
        // taken branch overrides load-use
        step(1, 7, 2, LD, 7, 1, ALU, 1);
        step(1, 0, 0, ALU, 0, 0, ALU, 1);
        // three wait cycles on a load, then ready
        repeat (3) step(1, 4, 4, LD, 4, 1, LD, 0);
        step(1, 4, 4, LD, 4, 1, LD, 1);
        step(1, 0, 0, ALU, 0, 0, ST, 1);
        // back-to-back stores: each wait run restarts its count
        repeat (3) step(1, 0, 0, ALU, 0, 0, ST, 0);
        step(1, 0, 0, ALU, 0, 0, ST, 1);
        repeat (3) step(1, 0, 0, ALU, 0, 0, ST, 0);
        step(1, 0, 0, ALU, 0, 0, ALU, 1);
        // reset in the middle of a wait
        repeat (2) step(1, 0, 0, ALU, 0, 0, LD, 0);
        step(0, 0, 0, ALU, 0, 0, LD, 0);
        step(1, 2, 0, LD, 2, 0, ALU, 1);
        step(1, 0, 0, ALU, 0, 0, ALU, 1);
        // watchdog: stuck memory, then ready has no effect
        repeat (6) step(1, 0, 0, ALU, 0, 1, LD, 0);
        repeat (3) step(1, 1, 1, LD, 1, 1, ALU, 1);
        step(0, 0, 0, ALU, 0, 0, ALU, 1);
        step(1, 0, 0, ALU, 0, 0, ALU, 1);
        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rand_step(($urandom_range(0, 79) != 0));
        end
        step(1, 0, 0, ALU, 0, 0, ALU, 1);
        done = 1;
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                       ex_mem_en, mem_wb_en, mem_wb_flush};
                chk("controls", CW'(act), CW'(e.ctl));
                chk("ctrl_state", CW'(ctrl_state), CW'(e.st));
                chk("mem_timeout_err", CW'(mem_timeout_err), CW'(e.err));
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
                chk("flush_without_enable",
                    CW'((if_id_flush & ~if_id_en) | (id_ex_flush & ~id_ex_en) |
                        (mem_wb_flush & ~mem_wb_en)), '0);
            end
            if (done) break;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "bench timeout");
    end

endmodule
